// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the processor-memory arbiter:
//   - bus_cmd_e   : memory bus command encoding (BUS_NONE/BUS_LOAD/BUS_STORE)
//   - OWNER_*     : which requester a load tag belongs to (and the round-robin
//                   pointer encoding)
//   - tag_entry_t : one tag-table entry {valid, owner, lsq_idx}
// The lsq_idx field width is LSQ_IDX_W; the arbiter's LSQ_IDX parameter must
// not exceed it.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSQ = 1'b1;

    localparam int LSQ_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic                 owner;
        logic [LSQ_IDX_W-1:0] lsq_idx;
    } tag_entry_t;

endpackage

// File: rtl/mem_arbiter_tag_table.sv
// mem_tag_table
// Tag-indexed record of outstanding loads plus the outstanding-load counter.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   alloc_en/tag/owner/idx: record a granted load under alloc_tag
//   ret_tag               : tag of data returning from memory (0 = none)
//   ret_entry             : current contents of entry[ret_tag]
//   ret_hit               : ret_tag is nonzero and its entry is valid
//   outstanding           : number of loads in flight
//   full                  : outstanding has reached MAX_OUT
// A return and an allocation of the same tag in one cycle is legal: the
// lookup sees the old contents and the entry ends up holding the new load.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int LSQ_IDX = 3,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_en,
    input  logic [TAG_W-1:0]   alloc_tag,
    input  logic               alloc_owner,
    input  logic [LSQ_IDX-1:0] alloc_idx,
    input  logic [TAG_W-1:0]   ret_tag,
    output tag_entry_t         ret_entry,
    output logic               ret_hit,
    output logic [TAG_W-1:0]   outstanding,
    output logic               full
);

    localparam int DEPTH = 1 << TAG_W;

    tag_entry_t         table_q [DEPTH];
    tag_entry_t         table_d [DEPTH];
    logic [TAG_W-1:0]   outstanding_q;
    logic [TAG_W-1:0]   outstanding_d;

    assign ret_entry   = table_q[ret_tag];
    assign ret_hit     = (ret_tag != '0) && ret_entry.valid;
    assign outstanding = outstanding_q;
    assign full        = (outstanding_q == TAG_W'(MAX_OUT));

    always_comb begin
        table_d = table_q;
        // Free first so a same-tag allocation in this cycle overwrites it.
        if (ret_hit) begin
            table_d[ret_tag] = '0;
        end
        if (alloc_en) begin
            table_d[alloc_tag].valid   = 1'b1;
            table_d[alloc_tag].owner   = alloc_owner;
            table_d[alloc_tag].lsq_idx = LSQ_IDX_W'(alloc_idx);
        end
    end

    // Alloc and free together cancel; bounds guard against wrapping.
    always_comb begin
        outstanding_d = outstanding_q;
        if (alloc_en && !ret_hit && (outstanding_q != TAG_W'(MAX_OUT))) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!alloc_en && ret_hit && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            outstanding_q <= '0;
        end else begin
            table_q       <= table_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single processor-memory port between the LSQ (loads/stores) and
// instruction fetch (loads only), and routes returning load data back to the
// requester that issued it.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   lsq_cmd/addr/data/idx         : LSQ request (BUS_NONE/LOAD/STORE)
//   lsq_grant                     : LSQ request accepted this cycle
//   lsq_resp_valid/idx/data       : returned LSQ load (one cycle pulse)
//   if_req/if_addr, if_grant      : fetch load request and its acceptance
//   if_resp_valid/data            : returned fetch load (one cycle pulse)
//   mem_cmd/addr/wdata            : command to memory (combinational)
//   mem_response                  : nonzero = accepted, value is the tag
//   mem_rdata/mem_tag             : returning data and its tag (0 = none)
//   outstanding                   : loads currently in flight
//   tag_err                       : sticky, data returned on an unknown tag
// Handshake: a requester holds its request until it sees its grant; grant is
// asserted in the same cycle the request is selected and memory answers with
// a nonzero tag. Responses are never stalled.
// Build option: define MEM_ARB_RR_EN for round-robin priority between the two
// requesters; otherwise the LSQ always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int LSQ_IDX = 3,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         lsq_cmd,
    input  logic [63:0]        lsq_addr,
    input  logic [63:0]        lsq_data,
    input  logic [LSQ_IDX-1:0] lsq_idx,
    output logic               lsq_grant,
    output logic               lsq_resp_valid,
    output logic [LSQ_IDX-1:0] lsq_resp_idx,
    output logic [63:0]        lsq_resp_data,
    input  logic               if_req,
    input  logic [63:0]        if_addr,
    output logic               if_grant,
    output logic               if_resp_valid,
    output logic [63:0]        if_resp_data,
    output logic [1:0]         mem_cmd,
    output logic [63:0]        mem_addr,
    output logic [63:0]        mem_wdata,
    input  logic [TAG_W-1:0]   mem_response,
    input  logic [63:0]        mem_rdata,
    input  logic [TAG_W-1:0]   mem_tag,
    output logic [TAG_W-1:0]   outstanding,
    output logic               tag_err
);

    logic lsq_is_load, lsq_is_store;
    logic lsq_elig, if_elig;
    logic lsq_sel, if_sel;
    logic full;
    logic alloc_en, alloc_owner;
    logic ret_hit;
    tag_entry_t ret_entry;

    logic               lsq_resp_valid_q, lsq_resp_valid_d;
    logic [LSQ_IDX-1:0] lsq_resp_idx_q,   lsq_resp_idx_d;
    logic [63:0]        lsq_resp_data_q,  lsq_resp_data_d;
    logic               if_resp_valid_q,  if_resp_valid_d;
    logic [63:0]        if_resp_data_q,   if_resp_data_d;
    logic               tag_err_q,        tag_err_d;

    assign lsq_is_load  = (lsq_cmd == BUS_LOAD);
    assign lsq_is_store = (lsq_cmd == BUS_STORE);

    // Loads wait while the tag budget is exhausted; stores never allocate.
    assign lsq_elig = lsq_is_store || (lsq_is_load && !full);
    assign if_elig  = if_req && !full;

`ifdef MEM_ARB_RR_EN
    // prio_q names the requester that wins a tie; it flips after each grant.
    logic prio_q, prio_d;

    assign lsq_sel = lsq_elig && !(if_elig && (prio_q == OWNER_IF));
    assign if_sel  = if_elig && !(lsq_elig && (prio_q == OWNER_LSQ));

    always_comb begin
        prio_d = prio_q;
        if (lsq_grant) begin
            prio_d = OWNER_IF;
        end else if (if_grant) begin
            prio_d = OWNER_LSQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= OWNER_LSQ;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign lsq_sel = lsq_elig;
    assign if_sel  = if_elig && !lsq_elig;
`endif

    assign lsq_grant = lsq_sel && (mem_response != '0);
    assign if_grant  = if_sel  && (mem_response != '0);

    always_comb begin
        mem_cmd   = BUS_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (lsq_sel) begin
            mem_cmd  = lsq_cmd;
            mem_addr = lsq_addr;
            if (lsq_is_store) begin
                mem_wdata = lsq_data;
            end
        end else if (if_sel) begin
            mem_cmd  = BUS_LOAD;
            mem_addr = if_addr;
        end
    end

    assign alloc_en    = (lsq_grant && lsq_is_load) || if_grant;
    assign alloc_owner = lsq_grant ? OWNER_LSQ : OWNER_IF;

    mem_tag_table #(
        .TAG_W   (TAG_W),
        .LSQ_IDX (LSQ_IDX),
        .MAX_OUT (MAX_OUT)
    ) u_tag_table (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem_response),
        .alloc_owner (alloc_owner),
        .alloc_idx   (lsq_idx),
        .ret_tag     (mem_tag),
        .ret_entry   (ret_entry),
        .ret_hit     (ret_hit),
        .outstanding (outstanding),
        .full        (full)
    );

    // Response registers: valids pulse for one cycle, payload holds.
    always_comb begin
        lsq_resp_valid_d = ret_hit && (ret_entry.owner == OWNER_LSQ);
        if_resp_valid_d  = ret_hit && (ret_entry.owner == OWNER_IF);
        lsq_resp_idx_d   = lsq_resp_idx_q;
        lsq_resp_data_d  = lsq_resp_data_q;
        if_resp_data_d   = if_resp_data_q;
        if (lsq_resp_valid_d) begin
            lsq_resp_idx_d  = LSQ_IDX'(ret_entry.lsq_idx);
            lsq_resp_data_d = mem_rdata;
        end
        if (if_resp_valid_d) begin
            if_resp_data_d = mem_rdata;
        end
        tag_err_d = tag_err_q || ((mem_tag != '0) && !ret_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lsq_resp_valid_q <= 1'b0;
            lsq_resp_idx_q   <= '0;
            lsq_resp_data_q  <= '0;
            if_resp_valid_q  <= 1'b0;
            if_resp_data_q   <= '0;
            tag_err_q        <= 1'b0;
        end else begin
            lsq_resp_valid_q <= lsq_resp_valid_d;
            lsq_resp_idx_q   <= lsq_resp_idx_d;
            lsq_resp_data_q  <= lsq_resp_data_d;
            if_resp_valid_q  <= if_resp_valid_d;
            if_resp_data_q   <= if_resp_data_d;
            tag_err_q        <= tag_err_d;
        end
    end

    assign lsq_resp_valid = lsq_resp_valid_q;
    assign lsq_resp_idx   = lsq_resp_idx_q;
    assign lsq_resp_data  = lsq_resp_data_q;
    assign if_resp_valid  = if_resp_valid_q;
    assign if_resp_data   = if_resp_data_q;
    assign tag_err        = tag_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter (MAX_OUT=2). Returning loads are pushed to
// per-owner expected queues when the tag is driven and popped one cycle later.
module tb_mem_arbiter;

    localparam int TAG_W   = 4;
    localparam int LSQ_IDX = 3;
    localparam int MAX_OUT = 2;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]         lsq_cmd;
    logic [63:0]        lsq_addr, lsq_data;
    logic [LSQ_IDX-1:0] lsq_idx;
    logic               lsq_grant, lsq_resp_valid;
    logic [LSQ_IDX-1:0] lsq_resp_idx;
    logic [63:0]        lsq_resp_data;
    logic               if_req;
    logic [63:0]        if_addr;
    logic               if_grant, if_resp_valid;
    logic [63:0]        if_resp_data;
    logic [1:0]         mem_cmd;
    logic [63:0]        mem_addr, mem_wdata;
    logic [TAG_W-1:0]   mem_response, mem_tag;
    logic [63:0]        mem_rdata;
    logic [TAG_W-1:0]   outstanding;
    logic               tag_err;

    mem_arbiter #(
        .TAG_W   (TAG_W),
        .LSQ_IDX (LSQ_IDX),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lsq_cmd        (lsq_cmd),
        .lsq_addr       (lsq_addr),
        .lsq_data       (lsq_data),
        .lsq_idx        (lsq_idx),
        .lsq_grant      (lsq_grant),
        .lsq_resp_valid (lsq_resp_valid),
        .lsq_resp_idx   (lsq_resp_idx),
        .lsq_resp_data  (lsq_resp_data),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_grant       (if_grant),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .mem_cmd        (mem_cmd),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_response   (mem_response),
        .mem_rdata      (mem_rdata),
        .mem_tag        (mem_tag),
        .outstanding    (outstanding),
        .tag_err        (tag_err)
    );

    // scoreboard
    logic [LSQ_IDX+63:0] lsq_exp_q[$];
    logic [63:0]         if_exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_resp();
        logic [LSQ_IDX+63:0] le;
        logic [63:0]         ie;
        chk("lsq_resp_valid", lsq_resp_valid, lsq_exp_q.size() != 0);
        if (lsq_exp_q.size() != 0) begin
            le = lsq_exp_q.pop_front();
            chk("lsq_resp", {lsq_resp_idx, lsq_resp_data}, le);
        end
        chk("if_resp_valid", if_resp_valid, if_exp_q.size() != 0);
        if (if_exp_q.size() != 0) begin
            ie = if_exp_q.pop_front();
            chk("if_resp_data", if_resp_data, ie);
        end
    endtask

    // driver tasks
    task automatic set_idle();
        lsq_cmd = 2'd0; lsq_addr = '0; lsq_data = '0; lsq_idx = '0;
        if_req = 1'b0; if_addr = '0;
        mem_response = '0; mem_rdata = '0; mem_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_resp();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic lsq_drive(input logic [1:0] cmd, input logic [63:0] addr,
                             input logic [63:0] data, input logic [LSQ_IDX-1:0] idx);
        lsq_cmd = cmd; lsq_addr = addr; lsq_data = data; lsq_idx = idx;
    endtask

    task automatic ret_lsq(input logic [TAG_W-1:0] tag, input logic [63:0] data,
                           input logic [LSQ_IDX-1:0] idx);
        mem_tag = tag; mem_rdata = data;
        lsq_exp_q.push_back({idx, data});
    endtask

    task automatic ret_if(input logic [TAG_W-1:0] tag, input logic [63:0] data);
        mem_tag = tag; mem_rdata = data;
        if_exp_q.push_back(data);
    endtask

    logic exp_lsq, prev_lsq;

    initial begin
        reset = 1'b1;
        set_idle();
        do_reset();
        settle();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_lsq_resp_data", lsq_resp_data, 0);
        chk("rst_lsq_resp_idx", lsq_resp_idx, 0);
        chk("rst_if_resp_data", if_resp_data, 0);
        chk("idle_mem_cmd", mem_cmd, 0);

        // LSQ load, tag 3, returns 0xDEAD one cycle later
        lsq_drive(2'd1, 64'h100, 64'h0, 3'd5); mem_response = 4'd3;
        settle();
        chk("t1_mem_cmd", mem_cmd, 1);
        chk("t1_mem_addr", mem_addr, 64'h100);
        chk("t1_mem_wdata", mem_wdata, 0);
        chk("t1_lsq_grant", lsq_grant, 1);
        chk("t1_if_grant", if_grant, 0);
        tick(); set_idle(); settle();
        chk("t1_out_1", outstanding, 1);
        ret_lsq(4'd3, 64'hDEAD, 3'd5);
        tick(); set_idle(); settle();
        chk("t1_out_0", outstanding, 0);

        // store competes with fetch; store wins and allocates nothing
        do_reset();
        lsq_drive(2'd2, 64'h200, 64'h1234, 3'd0); if_req = 1'b1; if_addr = 64'h300;
        mem_response = 4'd2;
        settle();
        chk("t2_mem_cmd", mem_cmd, 2);
        chk("t2_mem_addr", mem_addr, 64'h200);
        chk("t2_mem_wdata", mem_wdata, 64'h1234);
        chk("t2_lsq_grant", lsq_grant, 1);
        chk("t2_if_grant", if_grant, 0);
        tick(); set_idle(); settle();
        chk("t2_out", outstanding, 0);
        mem_tag = 4'd2; mem_rdata = 64'h5555;
        tick(); set_idle(); settle();
        chk("t2_tag_err", tag_err, 1);
        do_reset(); settle();
        chk("t2_tag_err_cleared", tag_err, 0);

        // outstanding limit: loads block at 2, store still issues
        lsq_drive(2'd1, 64'h400, 64'h0, 3'd1); mem_response = 4'd1;
        settle(); chk("t3_lsq_grant_a", lsq_grant, 1);
        tick(); set_idle();
        if_req = 1'b1; if_addr = 64'h500; mem_response = 4'd5;
        settle(); chk("t3_if_grant_a", if_grant, 1);
        tick(); set_idle(); settle();
        chk("t3_out_full", outstanding, 2);
        lsq_drive(2'd1, 64'h600, 64'h0, 3'd2); if_req = 1'b1; if_addr = 64'h508;
        mem_response = 4'd6;
        settle();
        chk("t3_blk_cmd", mem_cmd, 0);
        chk("t3_blk_lsq_grant", lsq_grant, 0);
        chk("t3_blk_if_grant", if_grant, 0);
        tick();
        if_req = 1'b0;
        lsq_drive(2'd2, 64'h700, 64'hABCD, 3'd0);
        settle();
        chk("t3_st_cmd", mem_cmd, 2);
        chk("t3_st_grant", lsq_grant, 1);
        chk("t3_st_wdata", mem_wdata, 64'hABCD);
        tick();
        lsq_drive(2'd1, 64'h600, 64'h0, 3'd2);
        ret_lsq(4'd1, 64'hA1, 3'd1);
        settle();
        chk("t3_out_still_2", outstanding, 2);
        chk("t3_ret_cycle_grant", lsq_grant, 0);
        tick(); mem_tag = '0; settle();
        chk("t3_out_after_ret", outstanding, 1);
        chk("t3_load_issues", lsq_grant, 1);
        chk("t3_load_addr", mem_addr, 64'h600);
        tick(); set_idle(); settle();
        chk("t3_out_2b", outstanding, 2);
        ret_if(4'd5, 64'hB5);
        tick(); set_idle();
        ret_lsq(4'd6, 64'hC6, 3'd2);
        tick(); set_idle(); settle();
        chk("t3_out_end", outstanding, 0);

        // same tag returned and re-granted in one cycle
        lsq_drive(2'd1, 64'h800, 64'h0, 3'd3); mem_response = 4'd4;
        tick(); set_idle();
        ret_lsq(4'd4, 64'hD4, 3'd3);
        if_req = 1'b1; if_addr = 64'h900; mem_response = 4'd4;
        settle(); chk("t4_if_grant", if_grant, 1);
        tick(); set_idle(); settle();
        chk("t4_out_same", outstanding, 1);
        ret_if(4'd4, 64'hE4);
        tick(); set_idle(); settle();
        chk("t4_out_0", outstanding, 0);
        chk("t4_tag_err", tag_err, 0);

        // memory refuses for three cycles, fetch holds its request
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; if_addr = 64'hA00; mem_response = '0;
            settle();
            chk("t5_no_grant", if_grant, 0);
            chk("t5_cmd", mem_cmd, 1);
            chk("t5_addr", mem_addr, 64'hA00);
            tick();
        end
        mem_response = 4'd7;
        settle(); chk("t5_grant", if_grant, 1);
        tick(); set_idle(); settle();
        chk("t5_out", outstanding, 1);
        ret_if(4'd7, 64'hF7);
        tick(); set_idle(); settle();
        chk("t5_out_0", outstanding, 0);

        // both requesters load continuously
        do_reset();
        prev_lsq = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_lsq = (i % 2 == 0);
`else
            exp_lsq = 1'b1;
`endif
            lsq_drive(2'd1, 64'h1000 + 64'(i * 8), 64'h0, 3'(i));
            if_req = 1'b1; if_addr = 64'h2000 + 64'(i * 8);
            mem_response = 4'(8 + i);
            if (i > 0) begin
                if (prev_lsq) ret_lsq(4'(8 + i - 1), 64'h5000 + 64'(i - 1), 3'(i - 1));
                else          ret_if(4'(8 + i - 1), 64'h5000 + 64'(i - 1));
            end
            settle();
            chk("t6_lsq_grant", lsq_grant, exp_lsq);
            chk("t6_if_grant", if_grant, !exp_lsq);
            chk("t6_addr", mem_addr, exp_lsq ? 64'h1000 + 64'(i * 8) : 64'h2000 + 64'(i * 8));
            prev_lsq = exp_lsq;
            tick(); settle();
            chk("t6_out", outstanding, 1);
        end
        set_idle();
        if (prev_lsq) ret_lsq(4'd11, 64'h5003, 3'd3);
        else          ret_if(4'd11, 64'h5003);
        tick(); set_idle(); settle();
        chk("t6_out_0", outstanding, 0);

        // reset in the middle of traffic
        lsq_drive(2'd1, 64'h3000, 64'h0, 3'd7); mem_response = 4'd12;
        tick();
        if_req = 1'b1; if_addr = 64'h3100; mem_response = 4'd13;
        reset = 1'b1;
        tick();
        reset = 1'b0; set_idle(); settle();
        chk("t7_out_reset", outstanding, 0);
        lsq_drive(2'd1, 64'h3000, 64'h0, 3'd7); if_req = 1'b1; if_addr = 64'h3100;
        mem_response = 4'd14;
        settle();
        chk("t7_lsq_first", lsq_grant, 1);
        chk("t7_if_wait", if_grant, 0);
        tick(); set_idle();
        ret_lsq(4'd14, 64'h6014, 3'd7);
        tick(); set_idle();
        mem_tag = 4'd12; mem_rdata = 64'h7777;
        tick(); set_idle(); settle();
        chk("t7_tag_err", tag_err, 1);
        chk("t7_out", outstanding, 0);

        chk("lsq_q_drained", lsq_exp_q.size(), 0);
        chk("if_q_drained", if_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single processor-memory port between the LSQ (loads and stores) and instruction fetch (loads only).
- Each cycle, selects one requester and drives the memory command.
- Records each accepted load's memory tag with its owner and LSQ index; routes returning data back to that owner.
- Sits between lsq/fetch and the memory interface (mem2proc_* / proc2mem_*).

Parameters:
- TAG_W, 4, memory tag width; tag 0 = "not accepted".
- LSQ_IDX, 3, LSQ index width carried with LSQ loads.
- MAX_OUT, 8, maximum outstanding loads (1..2^TAG_W-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lsq_cmd  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- lsq_addr  in  64  LSQ address
- lsq_data  in  64  store data
- lsq_idx  in  LSQ_IDX  LSQ entry index of the request
- lsq_grant  out  1  LSQ request accepted by memory this cycle
- lsq_resp_valid  out  1  load data for LSQ valid
- lsq_resp_idx  out  LSQ_IDX  LSQ entry index of returned load
- lsq_resp_data  out  64  returned load data
- if_req  in  1  fetch load request
- if_addr  in  64  fetch address
- if_grant  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  fetch data valid
- if_resp_data  out  64  fetch data
- mem_cmd  out  2  command to memory
- mem_addr  out  64  address to memory
- mem_wdata  out  64  store data to memory
- mem_response  in  TAG_W  nonzero = accepted, value is the tag
- mem_rdata  in  64  returned data
- mem_tag  in  TAG_W  tag of returned data; 0 = none
- outstanding  out  TAG_W  count of outstanding loads
- tag_err  out  1  sticky: data returned for an unallocated tag

Behaviour:
- Reset (synchronous): clears the tag table valids, outstanding=0, tag_err=0, all resp_valid=0, resp data/idx=0, priority pointer to LSQ.
- Request path is combinational, same cycle. Selection:
  - LSQ wins over fetch unless the optional feature is enabled.
  - A load (from either requester) is ineligible while outstanding==MAX_OUT.
  - Stores are never blocked by the outstanding limit.
- mem_cmd/addr/wdata come from the selected requester. mem_cmd=BUS_NONE when nothing is selected. mem_wdata=0 when the command is not a store.
- Grant rule: grant = selected && mem_response!=0. Grants are mutually exclusive. An ungranted requester holds its request; the arbiter keeps no memory of it.
- Tag table: 2^TAG_W entries indexed by tag, each holding {valid, owner(0=IF,1=LSQ), lsq_idx}.
  - A granted load writes entry[mem_response] at the clock edge.
  - A granted store allocates nothing.
- Response path, 1-cycle latency: when mem_tag!=0 and entry[mem_tag].valid, the next cycle asserts the owner's resp_valid for exactly one cycle.
  - Carries mem_rdata (and lsq_idx for LSQ).
  - The entry is cleared and outstanding decrements.
- Unallocated returned tag: dropped; tag_err set until reset.
- outstanding: +1 per granted load, -1 per valid return; both in the same cycle = unchanged. Never wraps.
- Same tag returned and re-granted in one cycle: the response uses the old entry contents; the entry ends holding the new allocation (valid=1).
- Reset mid-operation: table is cleared; later returns for pre-reset tags set tag_err and produce no resp_valid.
- Responses never stall; owners must accept them.

Optional Feature:
- MEM_ARB_RR_EN.
- Defined: a round-robin pointer is used. After any grant, priority goes to the other requester. The pointer updates only on a grant.
- Undefined: fixed LSQ-over-fetch priority.

Decomposition:
- Shared package holds the BUS_NONE/BUS_LOAD/BUS_STORE encodings, owner encoding, and the tag-table entry typedef.
- One natural sub-module, mem_tag_table: indexed storage plus outstanding counter, with alloc/free ports and the same-cycle free/alloc rule.

Test Plan:
- LSQ load addr 0x100 idx 5, mem_response=3; later mem_tag=3 rdata=0xDEAD -> lsq_grant=1; next cycle lsq_resp_valid=1, idx=5, data=0xDEAD; outstanding 0->1->0.
- LSQ store and if_req in the same cycle, response=2 -> mem_cmd=BUS_STORE, lsq_grant=1, if_grant=0, no table entry; a later mem_tag=2 sets tag_err.
- MAX_OUT=2, two granted loads, third LSQ load plus a store -> load is blocked and the store issues; after one return, the load issues.
- Return tag 4 and re-grant tag 4 in one cycle -> old owner gets the response; entry 4 stays valid; outstanding unchanged.
- mem_response=0 with if_req held for 3 cycles -> if_grant=0 and the request is retried; on response=7, if_grant=1.
- With MEM_ARB_RR_EN, both requesters issue loads continuously -> grants alternate LSQ, IF, LSQ, IF...; reset asserted mid-stream -> outstanding=0, next grant goes to LSQ.
